// File: rtl/ddr_scratchpad_responder.sv
`default_nettype none
// ============================================================================
// Module   : ddr_scratchpad_responder
// Brief    : Responder for the single-beat DDR request interface. Queues
//            one-cycle read/write pulses and serves them strictly in order
//            from an on-chip word array after a fixed per-op latency.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_scratchpad_responder #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    MEM_WORDS     = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    QUEUE_DEPTH   = 4,
    parameter int                    READ_LATENCY  = 2,
    parameter int                    WRITE_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] ddr_address_i,
    input  logic                  ddr_w_en_i,
    input  logic [DATA_WIDTH-1:0] ddr_w_data_i,
    input  logic                  ddr_r_en_i,
    output logic                  ddr_w_done_o,
    output logic [DATA_WIDTH-1:0] ddr_r_data_o,
    output logic                  ddr_r_valid_o,
    output logic                  err_overflow_o,
    output logic                  err_conflict_o,
    output logic                  err_range_o
);

    localparam int c_ptr_w   = $clog2(QUEUE_DEPTH);
    localparam int c_idx_w   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int c_max_lat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_cnt_w   = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;

    localparam logic [c_cnt_w-1:0]    c_rd_load   = c_cnt_w'(READ_LATENCY - 1);
    localparam logic [c_cnt_w-1:0]    c_wr_load   = c_cnt_w'(WRITE_LATENCY - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]    c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]      c_count_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]      c_depth     = (c_ptr_w + 1)'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_mem_words = ADDR_WIDTH'(MEM_WORDS);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    // Request FIFO
    req_t                  r_fifo [QUEUE_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_count;

    // Service stage
    state_t                r_state;
    state_t                w_state_next;
    req_t                  r_svc;
    logic [c_cnt_w-1:0]    r_cnt;

    // Backing store: not reset, contents survive rst_ni
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic                  r_err_overflow;
    logic                  r_err_conflict;
    logic                  r_err_range;

    logic                  w_push_req;
    logic                  w_conflict;
    logic                  w_push_ok;
    logic                  w_not_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_respond;
    req_t                  w_new;
    req_t                  w_head;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_in_range;

    assign w_push_req  = ddr_r_en_i ^ ddr_w_en_i;
    assign w_conflict  = ddr_r_en_i & ddr_w_en_i;
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == c_depth);
    // A full queue still accepts when the head leaves in the same cycle
    assign w_push_ok   = w_push_req & (~w_full | w_pop);
    assign w_new       = {ddr_w_en_i, ddr_address_i, ddr_w_data_i};
    assign w_head      = r_fifo[r_rd_ptr];

    // Index wraps in address width, so addresses below the base land out of range
    assign w_index     = r_svc.addr - BASE_ADDR;
    assign w_in_range  = (w_index < c_mem_words);
    assign w_idx       = w_index[c_idx_w-1:0];

    // FIFO entry storage, no reset needed since occupancy is tracked separately
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= w_new;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: pop on idle or on the response cycle so chained requests overlap
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_respond    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SERVE;
                end
            end
            S_SERVE: begin
                if (r_cnt == '0) begin
                    w_respond = 1'b1;
                    if (w_not_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Service register and latency countdown
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_svc <= '0;
            r_cnt <= '0;
        end else if (w_pop) begin
            r_svc <= w_head;
            r_cnt <= w_head.wr ? c_wr_load : c_rd_load;
        end else if ((r_state == S_SERVE) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    // Array write on the response cycle of an in-range write
    always_ff @(posedge clk_i) begin
        if (w_respond && r_svc.wr && w_in_range) begin
            r_mem[w_idx] <= r_svc.data;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_overflow <= 1'b0;
            r_err_conflict <= 1'b0;
            r_err_range    <= 1'b0;
        end else begin
            if (w_push_req && !w_push_ok) begin
                r_err_overflow <= 1'b1;
            end
            if (w_conflict) begin
                r_err_conflict <= 1'b1;
            end
            if (w_respond && !w_in_range) begin
                r_err_range <= 1'b1;
            end
        end
    end

    assign ddr_r_valid_o  = w_respond & ~r_svc.wr;
    assign ddr_w_done_o   = w_respond & r_svc.wr;
    assign ddr_r_data_o   = (ddr_r_valid_o && w_in_range) ? r_mem[w_idx] : '0;
    assign err_overflow_o = r_err_overflow;
    assign err_conflict_o = r_err_conflict;
    assign err_range_o    = r_err_range;

endmodule
`default_nettype wire

// File: tb/tb_ddr_scratchpad_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_scratchpad_responder
// Brief    : Bench for ddr_scratchpad_responder. Two instances: A with the
//            default latencies and a non-zero base, B with a slow read path
//            to exercise queue overflow. Expected responses come from a
//            cycle-level transaction model (queue of expected responses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_scratchpad_responder;

    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam logic [31:0] BASE_B = 32'h0000_0000;
    localparam int          NEVER  = 1 << 30;

    logic clk;
    logic rst_n;

    logic        a_ren, a_wen, b_ren, b_wen;
    logic [31:0] a_addr, a_wd, b_addr, b_wd;
    logic        a_valid, a_done, a_ovf, a_cnf, a_rng;
    logic        b_valid, b_done, b_ovf, b_cnf, b_rng;
    logic [31:0] a_data, b_data;

    ddr_scratchpad_responder #(
        .BASE_ADDR (BASE_A)
    ) dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ddr_address_i  (a_addr),
        .ddr_w_en_i     (a_wen),
        .ddr_w_data_i   (a_wd),
        .ddr_r_en_i     (a_ren),
        .ddr_w_done_o   (a_done),
        .ddr_r_data_o   (a_data),
        .ddr_r_valid_o  (a_valid),
        .err_overflow_o (a_ovf),
        .err_conflict_o (a_cnf),
        .err_range_o    (a_rng)
    );

    ddr_scratchpad_responder #(
        .BASE_ADDR    (BASE_B),
        .QUEUE_DEPTH  (4),
        .READ_LATENCY (8)
    ) dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ddr_address_i  (b_addr),
        .ddr_w_en_i     (b_wen),
        .ddr_w_data_i   (b_wd),
        .ddr_r_en_i     (b_ren),
        .ddr_w_done_o   (b_done),
        .ddr_r_data_o   (b_data),
        .ddr_r_valid_o  (b_valid),
        .err_overflow_o (b_ovf),
        .err_conflict_o (b_cnf),
        .err_range_o    (b_rng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        bit          wr;
        logic [31:0] data;
    } resp_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc;
    int          last_resp;
    int          pend[$];          // pop cycle of every accepted request
    resp_t       exp_q[$];
    logic [31:0] mem [int];
    int          ovf_on, cnf_on, rng_on;
    int          m_rlat, m_wlat, m_qd;
    logic [31:0] m_base;
    bit          sel;              // 0 drives instance A, 1 drives instance B
    logic [36:0] obs_all, exp_all; // {valid, done, data[31:0], ovf, cnf, rng}

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        last_resp = -1000;
        ovf_on = NEVER;
        cnf_on = NEVER;
        rng_on = NEVER;
    endtask

    // Sample this cycle's outputs and compute what the model expects for them
    task automatic observe();
        resp_t       r;
        logic        ev, ed, ov, od;
        logic [31:0] edata, odata;
        logic [2:0]  of;
        @(negedge clk);
        if (!sel) begin
            ov = a_valid; od = a_done; odata = a_data; of = {a_ovf, a_cnf, a_rng};
        end else begin
            ov = b_valid; od = b_done; odata = b_data; of = {b_ovf, b_cnf, b_rng};
        end
        ev = 1'b0; ed = 1'b0; edata = 32'h0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            r = exp_q.pop_front();
            ev = !r.wr;
            ed = r.wr;
            if (!r.wr) edata = r.data;
        end
        obs_all = {ov, od, (ev ? odata : 32'h0), of};
        exp_all = {ev, ed, edata, (cyc >= ovf_on), (cyc >= cnf_on), (cyc >= rng_on)};
    endtask

    // Drive one cycle of request inputs and let the model accept or drop it
    task automatic drive(input bit ren, input bit wen, input logic [31:0] addr, input logic [31:0] wd);
        int          occ, lat, resp;
        bit          popnow, inr;
        logic [31:0] idx;
        resp_t       r;
        if (!sel) begin
            a_ren = ren; a_wen = wen; a_addr = addr; a_wd = wd;
            b_ren = 0; b_wen = 0; b_addr = 0; b_wd = 0;
        end else begin
            b_ren = ren; b_wen = wen; b_addr = addr; b_wd = wd;
            a_ren = 0; a_wen = 0; a_addr = 0; a_wd = 0;
        end
        if (ren && wen) begin
            if (cnf_on > cyc + 1) cnf_on = cyc + 1;
        end else if (ren || wen) begin
            occ = 0;
            popnow = 0;
            foreach (pend[i]) begin
                if (pend[i] >= cyc) occ++;
                if (pend[i] == cyc) popnow = 1;
            end
            if (occ < m_qd || popnow) begin
                lat  = wen ? m_wlat : m_rlat;
                resp = cyc + 1 + lat;
                if (last_resp + lat > resp) resp = last_resp + lat;
                last_resp = resp;
                pend.push_back(resp - lat);
                idx = addr - m_base;
                inr = (idx < 32'd1024);
                r.cyc = resp;
                r.wr = wen;
                r.data = 32'h0;
                if (wen && inr) mem[int'(idx)] = wd;
                if (!wen && inr) r.data = mem.exists(int'(idx)) ? mem[int'(idx)] : 32'hx;
                if (!inr && rng_on > resp + 1) rng_on = resp + 1;
                exp_q.push_back(r);
            end else if (ovf_on > cyc + 1) begin
                ovf_on = cyc + 1;
            end
        end
        cyc++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a_valid, a_done, a_data, a_ovf, a_cnf, a_rng, b_valid, b_done, b_data, b_ovf, b_cnf, b_rng} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got a=%b%b%h%b%b%b b=%b%b%h%b%b%b want all zero",
                     a_valid, a_done, a_data, a_ovf, a_cnf, a_rng, b_valid, b_done, b_data, b_ovf, b_cnf, b_rng);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            drive(0, 0, 0, 0);
        end
    endtask

    task automatic test_basic();
        int c0, ndone, nval, done_cyc, val_cyc;
        logic [31:0] vdata;
        c0 = cyc; ndone = 0; nval = 0; done_cyc = -1; val_cyc = -1; vdata = 0;
        for (int k = 0; k < 10; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL basic cyc=%0d got=%h want=%h", cyc - c0, obs_all, exp_all);
            end
            if (obs_all[35]) begin ndone++; done_cyc = cyc - c0; end
            if (obs_all[36]) begin nval++; val_cyc = cyc - c0; vdata = obs_all[34:3]; end
            if (k == 0)      drive(0, 1, BASE_A + 3, 32'h1234);
            else if (k == 2) drive(1, 0, BASE_A + 3, 32'h0);
            else             drive(0, 0, 0, 0);
        end
        n_checks++;
        if (ndone !== 1 || done_cyc !== 2) begin
            n_err++;
            $display("FAIL basic_done_timing got count=%0d cycle=%0d want count=1 cycle=2", ndone, done_cyc);
        end
        n_checks++;
        if (nval !== 1 || val_cyc !== 5 || vdata !== 32'h1234) begin
            n_err++;
            $display("FAIL basic_read_timing got count=%0d cycle=%0d data=%h want 1/5/1234", nval, val_cyc, vdata);
        end
    endtask

    task automatic test_chain();
        int nreq, nresp;
        logic [31:0] got[$];
        nresp = 0;
        observe();
        n_checks++;
        if (obs_all !== exp_all) begin
            n_err++;
            $display("FAIL chain cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
        end
        drive(0, 1, BASE_A, 32'h0);
        nreq = 1;
        for (int k = 0; k < 300 && nresp < 32; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL chain cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (obs_all[36]) got.push_back(obs_all[34:3]);
            if (obs_all[36] || obs_all[35]) begin
                nresp++;
                if (nreq < 16) begin
                    drive(0, 1, BASE_A + nreq, nreq * 3);
                    nreq++;
                end else if (nreq < 32) begin
                    drive(1, 0, BASE_A + (nreq - 16), 32'h0);
                    nreq++;
                end else begin
                    drive(0, 0, 0, 0);
                end
            end else begin
                drive(0, 0, 0, 0);
            end
        end
        n_checks++;
        if (nresp !== 32 || got.size() !== 16) begin
            n_err++;
            $display("FAIL chain_count got responses=%0d reads=%0d want 32/16", nresp, got.size());
        end
        foreach (got[i]) begin
            n_checks++;
            if (got[i] !== 32'(i * 3)) begin
                n_err++;
                $display("FAIL chain_data idx=%0d got=%h want=%h", i, got[i], 32'(i * 3));
            end
        end
        for (int k = 0; k < 4; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all || obs_all[2:0] !== 3'b000) begin
                n_err++;
                $display("FAIL chain_quiet cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            drive(0, 0, 0, 0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if ($urandom_range(0, 99) < 55) begin
                if ($urandom_range(0, 1) == 1)
                    drive(0, 1, BASE_A + $urandom_range(0, 15), $urandom);
                else
                    drive(1, 0, BASE_A + $urandom_range(0, 15), 32'h0);
            end else begin
                drive(0, 0, 0, 0);
            end
        end
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            drive(0, 0, 0, 0);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL random_timeout got outstanding=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_errors();
        int nresp;
        nresp = 0;
        for (int k = 0; k < 20; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL errors cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (obs_all[36] || obs_all[35]) nresp++;
            case (k)
                0:       drive(1, 1, BASE_A + 3, 32'hDEAD_BEEF);
                3:       drive(1, 0, BASE_A + 3, 32'h0);
                6:       drive(1, 0, BASE_A + 1024, 32'h0);
                10:      drive(0, 1, BASE_A - 1, 32'h5);
                13:      drive(1, 0, BASE_A + 0, 32'h0);
                default: drive(0, 0, 0, 0);
            endcase
        end
        n_checks++;
        if (nresp !== 4 || obs_all[1:0] !== 2'b11) begin
            n_err++;
            $display("FAIL errors_summary got responses=%0d cnf_rng=%b want 4/11", nresp, obs_all[1:0]);
        end
    endtask

    task automatic test_reset_midchain();
        logic [31:0] snap, rdata;
        int nval;
        snap = mem[3];
        nval = 0;
        rdata = 0;
        for (int k = 0; k < 5; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL midreset_fill cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            drive(1, 0, BASE_A + k, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        a_ren = 0; a_wen = 0;
        model_reset();
        #1;
        n_checks++;
        if ({a_valid, a_done, a_data, a_ovf, a_cnf, a_rng} !== '0) begin
            n_err++;
            $display("FAIL midreset_immediate got=%b%b%h%b%b%b want all zero", a_valid, a_done, a_data, a_ovf, a_cnf, a_rng);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({a_valid, a_done, a_data, a_ovf, a_cnf, a_rng} !== '0) begin
                n_err++;
                $display("FAIL midreset_hold k=%0d got=%b%b%h want zero", k, a_valid, a_done, a_data);
            end
        end
        rst_n = 1'b1;
        cyc = cyc + 5;
        for (int k = 0; k < 10; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL midreset_after cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (obs_all[36]) begin nval++; rdata = obs_all[34:3]; end
            if (k == 1) drive(1, 0, BASE_A + 3, 32'h0);
            else        drive(0, 0, 0, 0);
        end
        n_checks++;
        if (nval !== 1 || rdata !== snap) begin
            n_err++;
            $display("FAIL midreset_retained got count=%0d data=%h want 1/%h", nval, rdata, snap);
        end
    endtask

    task automatic test_overflow();
        int c0, ovf_first;
        logic [31:0] got[$];
        sel = 1;
        model_reset();
        mem.delete();
        m_rlat = 8; m_wlat = 1; m_qd = 4; m_base = BASE_B;
        for (int k = 0; k < 20; k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL ovf_fill cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
            end
            if (k % 3 == 0 && k < 15) drive(0, 1, BASE_B + k / 3, 32'(100 + k / 3));
            else                      drive(0, 0, 0, 0);
        end
        c0 = cyc;
        ovf_first = -1;
        for (int k = 0; k < 100 && (k < 7 || exp_q.size() > 0); k++) begin
            observe();
            n_checks++;
            if (obs_all !== exp_all) begin
                n_err++;
                $display("FAIL ovf_reads cyc=%0d got=%h want=%h", cyc - c0, obs_all, exp_all);
            end
            if (obs_all[2] && ovf_first < 0) ovf_first = cyc - c0;
            if (obs_all[36]) got.push_back(obs_all[34:3]);
            if (k < 7) drive(1, 0, BASE_B + k, 32'h0);
            else       drive(0, 0, 0, 0);
        end
        n_checks++;
        if (ovf_first !== 6) begin
            n_err++;
            $display("FAIL ovf_rise got cycle=%0d want 6", ovf_first);
        end
        n_checks++;
        if (got.size() !== 5) begin
            n_err++;
            $display("FAIL ovf_valid_count got=%0d want 5", got.size());
        end
        foreach (got[i]) begin
            n_checks++;
            if (got[i] !== 32'(100 + i)) begin
                n_err++;
                $display("FAIL ovf_data idx=%0d got=%h want=%h", i, got[i], 32'(100 + i));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_ren = 0; a_wen = 0; a_addr = 0; a_wd = 0;
        b_ren = 0; b_wen = 0; b_addr = 0; b_wd = 0;
        sel = 0;
        cyc = 0;
        m_rlat = 2; m_wlat = 1; m_qd = 4; m_base = BASE_A;
        model_reset();
        test_reset();
        test_basic();
        test_chain();
        test_random();
        test_errors();
        test_reset_midchain();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
